sumnb_pipe: RTL and testbench

- Parametrised, pipelined N-bit adder/subtractor. Successor to the 4-bit ripple-carry adder.
- The operand is split into STAGES equal chunks. Each chunk is a ripple-carry slice built from sum1b cells, with a register stage after each chunk, so carries ripple across one chunk per cycle.
- Valid/ready handshake on both sides, full backpressure, one result per cycle sustained. Used wherever wide add/sub must meet timing that a flat ripple chain cannot.

---
 rtl/sumnb_pipe.sv | 195 +++++++++++++++++++
 tb/tb_sumnb_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumnb_pipe.sv
// ---------------------------------------------------------------------------
// sumnb_pipe : pipelined WIDTH-bit adder/subtractor.
//
// The operands are cut into STAGES chunks of CHUNK = WIDTH/STAGES bits. Each
// stage ripples one chunk through a chain of sum1b full adders and registers
// the partial sum, the chunk carry and the operand bits still to be added.
// Carries therefore cross one chunk per clock. A valid/ready handshake with
// full backpressure sustains one result per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle (combinational from out_ready)
//   a, b       operands (unsigned or two's complement)
//   ci         carry-in, add mode only
//   sub        0: a + b + ci   1: a - b (a + ~b + 1, ci ignored)
//   out_valid  result beat valid
//   out_ready  downstream takes the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
// ---------------------------------------------------------------------------
module sumnb_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("sumnb_pipe: WIDTH must be a positive multiple of STAGES");
    end

    // One full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] sum1b(input logic x, input logic y, input logic cin);
        return {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
    endfunction

    // CHUNK-bit ripple slice built from sum1b cells: returns {carry_out, sum}.
    function automatic logic [CHUNK:0] ripple(input logic [CHUNK-1:0] x,
                                              input logic [CHUNK-1:0] y,
                                              input logic             cin);
        logic             c;
        logic [CHUNK-1:0] s;
        logic [1:0]       fa;
        c  = cin;
        s  = '0;
        fa = '0;
        for (int i = 0; i < CHUNK; i++) begin
            fa   = sum1b(x[i], y[i], c);
            s[i] = fa[0];
            c    = fa[1];
        end
        return {c, s};
    endfunction

    // What each stage sees from upstream. Operand vectors are kept shifted so
    // the chunk a stage works on always sits at bits [CHUNK-1:0].
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] stage_v;
    logic [STAGES:0]   rdy;

    // Subtraction is a + ~b + 1: invert b once here and force the carry-in.
    assign a_in[0] = a;
    assign b_in[0] = sub ? ~b : b;
    assign s_in[0] = '0;
    assign v_in[0] = in_valid;
    assign c_in[0] = sub | ci;

    // A stage may load when it is empty or when the stage after it moves on.
    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;

        logic             v_q, v_d;
        logic             carry_q, carry_d;
        logic [WIDTH-1:0] sum_q, sum_d;
        logic [CHUNK:0]   slice;
        logic             load;

        assign rdy[k]     = !v_q | rdy[k+1];
        assign stage_v[k] = v_q;
        assign slice      = ripple(a_in[k][CHUNK-1:0], b_in[k][CHUNK-1:0], c_in[k]);
        // Data only moves for a real beat; a bubble leaves held data untouched.
        assign load       = rdy[k] & v_in[k];

        // NOTE: every always_comb output gets its hold value first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        always_comb begin
            v_d     = rdy[k] ? v_in[k] : v_q;
            carry_d = carry_q;
            sum_d   = sum_q;
            if (load) begin
                carry_d              = slice[CHUNK];
                sum_d                = s_in[k];
                sum_d[LO +: CHUNK]   = slice[CHUNK-1:0];
            end
        end

        // NOTE: data registers are reset as well as valid bits, because the
        // last stage drives sum/cout/ovf directly and those must read 0 in reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q     <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else begin
                // NOTE: non-blocking assignments so every stage samples the
                // pre-edge value of its neighbour, giving true pipeline behaviour.
                v_q     <= v_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_mid
            // Operand bits above the chunk just consumed.
            localparam int REM = WIDTH - (k + 1) * CHUNK;

            logic [REM-1:0] a_q, a_d;
            logic [REM-1:0] b_q, b_d;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (load) begin
                    a_d = a_in[k][CHUNK +: REM];
                    b_d = b_in[k][CHUNK +: REM];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end

            assign a_in[k+1] = WIDTH'(a_q);
            assign b_in[k+1] = WIDTH'(b_q);
            assign s_in[k+1] = sum_q;
            assign v_in[k+1] = v_q;
            assign c_in[k+1] = carry_q;
        end else begin : g_last
            logic ovf_q, ovf_d;

            // Carry into the MSB is recovered as s ^ a ^ b' of the top bit.
            always_comb begin
                ovf_d = ovf_q;
                if (load) begin
                    ovf_d = slice[CHUNK-1] ^ a_in[k][CHUNK-1] ^ b_in[k][CHUNK-1]
                          ^ slice[CHUNK];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end

            assign out_valid = v_q;
            assign sum       = sum_q;
            assign cout      = carry_q;
            assign ovf       = ovf_q;
        end
    end

endmodule

// File: tb/tb_sumnb_pipe.sv
// ---------------------------------------------------------------------------
// tb_sumnb_pipe : bench for sumnb_pipe in three configurations
// (16/4, 4/1, 8/8). Expected results come from an arithmetic model of
// add/subtract with signed-overflow detection; a scoreboard queue tracks
// beats in flight in the 16/4 instance and is checked every cycle.
// ---------------------------------------------------------------------------
module tb_sumnb_pipe;

    typedef struct packed {
        logic        v;
        logic        r;
        logic [15:0] s;
        logic        c;
        logic        o;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;

    // 16-bit, 4-stage instance
    logic        iv16, ir16, ci16, sub16, ov16, or16, c16, o16;
    logic [15:0] a16, b16, s16;
    // 4-bit, 1-stage instance
    logic        iv4, ir4, ci4, sub4, ov4, or4, c4, o4;
    logic [3:0]  a4, b4, s4;
    // 8-bit, 8-stage instance
    logic        iv8, ir8, ci8, sub8, ov8, or8, c8, o8;
    logic [7:0]  a8, b8, s8;

    int n_vec = 0;
    int n_err = 0;

    logic [17:0] q[$];
    logic        stall_prev;
    logic [17:0] held;

    always #5 clk = ~clk;

    sumnb_pipe #(.WIDTH(16), .STAGES(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .ci(ci16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
        .cout(c16), .ovf(o16));

    sumnb_pipe #(.WIDTH(4), .STAGES(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .ci(ci4), .sub(sub4), .out_valid(ov4), .out_ready(or4), .sum(s4),
        .cout(c4), .ovf(o4));

    sumnb_pipe #(.WIDTH(8), .STAGES(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .ci(ci8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
        .cout(c8), .ovf(o8));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {ovf, cout, sum}.
    function automatic logic [17:0] model(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic cin,
                                          input logic is_sub);
        longint md, ux, uy, res, sx, sy, st;
        logic   co, ov;
        logic [15:0] s;
        md  = longint'(1) << w;
        ux  = longint'(x) % md;
        uy  = longint'(y) % md;
        if (is_sub) begin
            res = ux - uy;
            co  = (ux >= uy);
        end else begin
            res = ux + uy + longint'(cin);
            co  = (res >= md);
        end
        s  = 16'((res + md) % md);
        sx = (ux >= md / 2) ? ux - md : ux;
        sy = (uy >= md / 2) ? uy - md : uy;
        st = is_sub ? (sx - sy) : (sx + sy + longint'(cin));
        ov = (st >= md / 2) || (st < -(md / 2));
        return {ov, co, s};
    endfunction

    function automatic obs_t obs(input int d);
        obs_t o;
        case (d)
            0:       o = '{v: ov16, r: ir16, s: s16,          c: c16, o: o16};
            1:       o = '{v: ov4,  r: ir4,  s: {12'h0, s4},  c: c4,  o: o4};
            default: o = '{v: ov8,  r: ir8,  s: {8'h0, s8},   c: c8,  o: o8};
        endcase
        return o;
    endfunction

    task automatic drive(input int d, input logic v, input logic [15:0] x,
                         input logic [15:0] y, input logic cin, input logic is_sub);
        case (d)
            0: begin iv16 = v; a16 = x;      b16 = y;      ci16 = cin; sub16 = is_sub; end
            1: begin iv4  = v; a4  = x[3:0]; b4  = y[3:0]; ci4  = cin; sub4  = is_sub; end
            default: begin iv8 = v; a8 = x[7:0]; b8 = y[7:0]; ci8 = cin; sub8 = is_sub; end
        endcase
    endtask

    // One isolated beat with out_ready high: checks latency and literal result.
    task automatic run_dir(input string name, input int d, input int w, input int lat,
                           input logic [15:0] x, input logic [15:0] y, input logic cin,
                           input logic is_sub, input logic [15:0] es, input logic ec,
                           input logic eo);
        obs_t o;
        check({name, "_model"}, 32'(model(w, x, y, cin, is_sub)), 32'({eo, ec, es}));
        @(posedge clk); #1;
        or16 = 1'b1;
        drive(d, 1'b1, x, y, cin, is_sub);
        @(negedge clk);
        o = obs(d);
        check({name, "_in_ready"}, 32'(o.r), 32'd1);
        @(posedge clk); #1;
        drive(d, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        if (lat > 1) begin
            repeat (lat - 2) @(posedge clk);
            @(negedge clk);
            o = obs(d);
            check({name, "_early_valid"}, 32'(o.v), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        o = obs(d);
        check({name, "_valid"}, 32'(o.v), 32'd1);
        check({name, "_sum"},   32'(o.s), 32'(es));
        check({name, "_cout"},  32'(o.c), 32'(ec));
        check({name, "_ovf"},   32'(o.o), 32'(eo));
    endtask

    // Scoreboard / compare process for the 16/4 instance.
    always @(negedge clk) begin
        logic [17:0] e;
        if (!rst_n) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            check("in_ready_rule", 32'(ir16), 32'(!(q.size() == 4 && !or16)));
            if (stall_prev) begin
                check("stall_valid", 32'(ov16), 32'd1);
                check("stall_hold", 32'({o16, c16, s16}), 32'(held));
            end
            if (ov16 && or16) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", 32'(ov16), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("stream_result", 32'({o16, c16, s16}), 32'(e));
                end
            end
            if (iv16 && ir16) q.push_back(model(16, a16, b16, ci16, sub16));
            stall_prev = ov16 && !or16;
            held       = {o16, c16, s16};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sent;
        int          cyc;
        int          waited;
        logic [15:0] ra, rb;
        logic        rci, rsub;

        rst_n = 1'b0;
        stall_prev = 1'b0;
        held = '0;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(2, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        or16 = 1'b1; or4 = 1'b1; or8 = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 32'(ov16), 32'd0);
        check("rst_sum",       32'(s16),  32'd0);
        check("rst_cout",      32'(c16),  32'd0);
        check("rst_ovf",       32'(o16),  32'd0);
        check("rst_out_valid8", 32'(ov8), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready16", 32'(ir16), 32'd1);
        check("rel_in_ready4",  32'(ir4),  32'd1);
        check("rel_in_ready8",  32'(ir8),  32'd1);

        // Directed vectors, 16/4
        run_dir("add_wrap",   0, 16, 4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_dir("add_ovf",    0, 16, 4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_dir("add_negovf", 0, 16, 4, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_dir("sub_borrow", 0, 16, 4, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_dir("sub_plain",  0, 16, 4, 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_dir("sub_ovf",    0, 16, 4, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_dir("add_ci",     0, 16, 4, 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
        // Other configurations
        run_dir("w4s1",       1, 4,  1, 16'h000F, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        run_dir("w8s8",       2, 8,  8, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Random stream with backpressure; the first cycles hold out_ready low
        // so the pipeline fills completely and in_ready must drop.
        sent = 0;
        cyc  = 0;
        ra = 16'($urandom); rb = 16'($urandom);
        rci = 1'($urandom); rsub = 1'($urandom);
        while (sent < 20 && cyc < 500) begin
            @(posedge clk); #1;
            or16 = (cyc < 6) ? 1'b0 : 1'($urandom_range(0, 1));
            drive(0, 1'b1, ra, rb, rci, rsub);
            @(negedge clk);
            if (ir16) begin
                sent++;
                ra = 16'($urandom); rb = 16'($urandom);
                rci = 1'($urandom); rsub = 1'($urandom);
            end
            cyc++;
        end
        check("stream_sent", 32'(sent), 32'd20);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        or16 = 1'b1;
        waited = 0;
        while (q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);

        // Reset with three beats in flight and a result waiting at the output
        @(posedge clk); #1;
        or16 = 1'b0;
        drive(0, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b1, 16'h2000, 16'h0003, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b1, 16'h4000, 16'h0004, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        waited = 0;
        while (!ov16 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("pre_rst_valid", 32'(ov16), 32'd1);
        check("pre_rst_sum",   32'(s16),  32'h2345);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ov16), 32'd0);
        check("mid_rst_sum",   32'(s16),  32'd0);
        check("mid_rst_cout",  32'(c16),  32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        or16 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(ov16), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
